// File: rtl/debug_uart_tx.sv
// Debug snapshot transmitter: a step pulse latches pc/alu/ctrl and sends them
// as an 8-byte UART 8N1 frame (A5, pc, alu MSB..LSB, ctrl, xor checksum).
module debug_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PC_W         = 5,
    parameter int DATA_W       = 32,
    parameter int CTRL_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              tx,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        drop_cnt,
    output logic [1:0]        dbg_state
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_bit_idx;
    logic [2:0]          r_byte_idx;
    logic [7:0]          r_shift;
    logic                r_tx;
    logic                r_busy;
    logic                r_overrun;
    logic [7:0]          r_drop_cnt;
    logic [7:0]          r_pc;
    logic [DATA_W-1:0]   r_alu;
    logic [CTRL_W-1:0]   r_ctrl;

    state_t              w_state_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [2:0]          w_bit_idx_next;
    logic [2:0]          w_byte_idx_next;
    logic [7:0]          w_shift_next;
    logic                w_tx_next;
    logic                w_accept;
    logic                w_drop;
    logic                w_cnt_done;
    logic [7:0]          w_pc_ext;
    logic [7:0]          w_checksum;
    logic [7:0]          w_cur_byte;

    // busy is registered, so a step on the edge where busy falls is still a drop.
    assign w_accept   = step & ~r_busy;
    assign w_drop     = step & r_busy;
    assign w_cnt_done = (r_cnt == CNT_LAST);
    assign w_pc_ext   = 8'(pc_in);

    assign w_checksum = r_pc ^ r_alu[31:24] ^ r_alu[23:16] ^ r_alu[15:8]
                      ^ r_alu[7:0] ^ r_ctrl;

    always_comb begin
        w_cur_byte = SYNC_BYTE;
        case (r_byte_idx)
            3'd0:    w_cur_byte = SYNC_BYTE;
            3'd1:    w_cur_byte = r_pc;
            3'd2:    w_cur_byte = r_alu[31:24];
            3'd3:    w_cur_byte = r_alu[23:16];
            3'd4:    w_cur_byte = r_alu[15:8];
            3'd5:    w_cur_byte = r_alu[7:0];
            3'd6:    w_cur_byte = r_ctrl;
            default: w_cur_byte = w_checksum;
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_bit_idx_next  = r_bit_idx;
        w_byte_idx_next = r_byte_idx;
        w_shift_next    = r_shift;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next    = S_START;
                    w_cnt_next      = '0;
                    w_bit_idx_next  = '0;
                    w_byte_idx_next = '0;
                end
            end
            S_START: begin
                if (w_cnt_done) begin
                    w_state_next   = S_DATA;
                    w_cnt_next     = '0;
                    w_bit_idx_next = '0;
                    w_shift_next   = w_cur_byte;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_cnt_done) begin
                    w_cnt_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        w_shift_next   = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (w_cnt_done) begin
                    w_cnt_next = '0;
                    if (r_byte_idx == 3'd7) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_byte_idx_next = r_byte_idx + 3'd1;
                        w_state_next    = S_START;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Line level is computed for the next state so tx comes straight from a flop.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
            r_byte_idx <= w_byte_idx_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
            r_busy     <= (w_state_next != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= '0;
            r_alu  <= '0;
            r_ctrl <= '0;
        end else if (w_accept) begin
            r_pc   <= w_pc_ext;
            r_alu  <= alu_in;
            r_ctrl <= ctrl_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign overrun   = r_overrun;
    assign drop_cnt  = r_drop_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: decodes the serial line at bit centres and compares
// against frames built from the snapshot values.
module tb_debug_uart_tx;
  localparam int CPB_S = 4;
  localparam int CPB_L = 434;
  localparam int MAXN  = 80 * CPB_L;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step_s = 1'b0;
  logic       step_l = 1'b0;
  logic [4:0] pc_in = '0;
  logic [31:0] alu_in = '0;
  logic [7:0] ctrl_in = '0;

  logic       tx_s, busy_s, ovr_s;
  logic [7:0] drop_s;
  logic [1:0] dbg_s;
  logic       tx_l, busy_l, ovr_l;
  logic [7:0] drop_l;
  logic [1:0] dbg_l;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  logic       samples [0:MAXN-1];
  logic [7:0] dec [0:7];
  bit         framing_ok;
  bit         uniform_ok;
  int         busy_hi;
  logic       end_busy;
  logic       end_tx;

  debug_uart_tx #(.CLKS_PER_BIT(CPB_S), .PC_W(5)) dut_s (
    .clk(clk), .rst(rst), .step(step_s), .pc_in(pc_in), .alu_in(alu_in),
    .ctrl_in(ctrl_in), .tx(tx_s), .busy(busy_s), .overrun(ovr_s),
    .drop_cnt(drop_s), .dbg_state(dbg_s)
  );

  debug_uart_tx #(.CLKS_PER_BIT(CPB_L), .PC_W(5)) dut_l (
    .clk(clk), .rst(rst), .step(step_l), .pc_in(pc_in), .alu_in(alu_in),
    .ctrl_in(ctrl_in), .tx(tx_l), .busy(busy_l), .overrun(ovr_l),
    .drop_cnt(drop_l), .dbg_state(dbg_l)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    step_s = 1'b0;
    step_l = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // reference model: the frame a PC terminal should log
  task automatic model_frame(input logic [4:0] pc, input logic [31:0] alu, input logic [7:0] ctrl);
    logic [7:0] fb [8];
    fb[0] = 8'hA5;
    fb[1] = {3'b000, pc};
    fb[2] = alu[31:24];
    fb[3] = alu[23:16];
    fb[4] = alu[15:8];
    fb[5] = alu[7:0];
    fb[6] = ctrl;
    fb[7] = 8'h00;
    for (int i = 1; i <= 6; i++) fb[7] = fb[7] ^ fb[i];
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(fb[i]);
  endtask

  // driver: one-cycle step; returns on the negedge right after the accepting edge
  task automatic send_step(input bit big);
    @(negedge clk);
    if (big) step_l = 1'b1; else step_s = 1'b1;
    @(negedge clk);
    step_s = 1'b0;
    step_l = 1'b0;
  endtask

  // records exactly one frame length of tx from the current negedge, then decodes
  task automatic capture(input bit big);
    int cpb = big ? CPB_L : CPB_S;
    int n = 80 * cpb;
    busy_hi = 0;
    for (int k = 0; k < n; k++) begin
      samples[k] = big ? tx_l : tx_s;
      if (big ? busy_l : busy_s) busy_hi++;
      @(negedge clk);
    end
    end_busy = big ? busy_l : busy_s;
    end_tx = big ? tx_l : tx_s;
    framing_ok = 1'b1;
    uniform_ok = 1'b1;
    for (int k = 0; k < n; k++)
      if (samples[k] !== samples[k - (k % cpb)]) uniform_ok = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (samples[(10 * b) * cpb + cpb / 2] !== 1'b0) framing_ok = 1'b0;
      if (samples[(10 * b + 9) * cpb + cpb / 2] !== 1'b1) framing_ok = 1'b0;
      for (int i = 0; i < 8; i++) dec[b][i] = samples[(10 * b + 1 + i) * cpb + cpb / 2];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_s, busy_s, ovr_s, drop_s} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_small: got tx/busy/ovr/drop=%b/%b/%b/%h want 1/0/0/00", tx_s, busy_s, ovr_s, drop_s);
    end
    total++;
    if ({tx_l, busy_l, ovr_l, drop_l} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_large: got tx/busy/ovr/drop=%b/%b/%b/%h want 1/0/0/00", tx_l, busy_l, ovr_l, drop_l);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    do_reset();
    pc_in = 5'h13; alu_in = 32'h12345678; ctrl_in = 8'h5A;
    model_frame(pc_in, alu_in, ctrl_in);
    send_step(1'b0);
    total++;
    if (tx_s !== 1'b0 || busy_s !== 1'b1) begin
      bad++;
      $display("FAIL single_latency: got tx=%b busy=%b want tx=0 busy=1", tx_s, busy_s);
    end
    capture(1'b0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dec[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL single_byte%0d: got %h want %h", i, dec[i], exp_q[i]);
      end
    end
    total++;
    if (framing_ok !== 1'b1 || uniform_ok !== 1'b1) begin
      bad++;
      $display("FAIL single_framing: got framing=%b uniform=%b want 1 1", framing_ok, uniform_ok);
    end
    total++;
    if (busy_hi != 320 || end_busy !== 1'b0 || end_tx !== 1'b1 || ovr_s !== 1'b0) begin
      bad++;
      $display("FAIL single_busy: got busy_cycles=%0d end_busy=%b end_tx=%b ovr=%b want 320 0 1 0", busy_hi, end_busy, end_tx, ovr_s);
    end
  endtask

  task automatic test_snapshot();
    do_reset();
    pc_in = 5'h13; alu_in = 32'h12345678; ctrl_in = 8'h5A;
    model_frame(pc_in, alu_in, ctrl_in);
    send_step(1'b0);
    fork
      begin
        @(negedge clk);
        pc_in = '1; alu_in = '1; ctrl_in = '1;
      end
    join_none
    capture(1'b0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dec[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL snapshot_byte%0d: got %h want %h", i, dec[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    pc_in = 5'($urandom); alu_in = $urandom; ctrl_in = 8'($urandom);
    model_frame(pc_in, alu_in, ctrl_in);
    send_step(1'b0);
    fork
      begin
        repeat (49) @(negedge clk);
        step_s = 1'b1;
        pc_in = ~pc_in; alu_in = ~alu_in;
        @(negedge clk);
        step_s = 1'b0;
      end
    join_none
    capture(1'b0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dec[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL overrun_byte%0d: got %h want %h", i, dec[i], exp_q[i]);
      end
    end
    total++;
    if (ovr_s !== 1'b1 || drop_s !== 8'd1 || busy_hi != 320) begin
      bad++;
      $display("FAIL overrun_flags: got ovr=%b drop=%0d busy_cycles=%0d want 1 1 320", ovr_s, drop_s, busy_hi);
    end
    pc_in = 5'($urandom); alu_in = $urandom; ctrl_in = 8'($urandom);
    model_frame(pc_in, alu_in, ctrl_in);
    send_step(1'b0);
    capture(1'b0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dec[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL overrun_next_byte%0d: got %h want %h", i, dec[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pc_in = 5'($urandom); alu_in = $urandom; ctrl_in = 8'($urandom);
    model_frame(pc_in, alu_in, ctrl_in);
    send_step(1'b0);
    // step rises for the edge where busy falls and stays for one more edge
    fork
      begin
        repeat (319) @(negedge clk);
        step_s = 1'b1;
      end
    join_none
    capture(1'b0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dec[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_first_byte%0d: got %h want %h", i, dec[i], exp_q[i]);
      end
    end
    total++;
    if (end_busy !== 1'b0 || drop_s !== 8'd1 || ovr_s !== 1'b1) begin
      bad++;
      $display("FAIL b2b_edge_drop: got busy=%b drop=%0d ovr=%b want 0 1 1", end_busy, drop_s, ovr_s);
    end
    pc_in = 5'($urandom); alu_in = $urandom; ctrl_in = 8'($urandom);
    model_frame(pc_in, alu_in, ctrl_in);
    @(negedge clk);
    step_s = 1'b0;
    capture(1'b0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dec[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_second_byte%0d: got %h want %h", i, dec[i], exp_q[i]);
      end
    end
    total++;
    if (busy_hi != 320 || drop_s !== 8'd1) begin
      bad++;
      $display("FAIL b2b_second_busy: got busy_cycles=%0d drop=%0d want 320 1", busy_hi, drop_s);
    end
  endtask

  task automatic test_step_held();
    do_reset();
    pc_in = 5'($urandom); alu_in = $urandom; ctrl_in = 8'($urandom);
    model_frame(pc_in, alu_in, ctrl_in);
    @(negedge clk);
    step_s = 1'b1;
    @(negedge clk);
    fork
      begin
        repeat (299) @(negedge clk);
        step_s = 1'b0;
      end
    join_none
    capture(1'b0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dec[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL held_byte%0d: got %h want %h", i, dec[i], exp_q[i]);
      end
    end
    total++;
    if (drop_s !== 8'd255 || ovr_s !== 1'b1 || busy_hi != 320 || end_busy !== 1'b0) begin
      bad++;
      $display("FAIL held_drops: got drop=%0d ovr=%b busy_cycles=%0d end_busy=%b want 255 1 320 0", drop_s, ovr_s, busy_hi, end_busy);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    pc_in = 5'($urandom); alu_in = $urandom; ctrl_in = 8'($urandom);
    send_step(1'b0);
    repeat (10) @(negedge clk);
    step_s = 1'b1;
    @(negedge clk);
    step_s = 1'b0;
    repeat (121) @(negedge clk);
    total++;
    if (busy_s !== 1'b1 || ovr_s !== 1'b1 || drop_s !== 8'd1) begin
      bad++;
      $display("FAIL midreset_pre: got busy=%b ovr=%b drop=%0d want 1 1 1", busy_s, ovr_s, drop_s);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({tx_s, busy_s, ovr_s, drop_s} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL midreset_post: got tx/busy/ovr/drop=%b/%b/%b/%h want 1/0/0/00", tx_s, busy_s, ovr_s, drop_s);
    end
    pc_in = 5'($urandom); alu_in = $urandom; ctrl_in = 8'($urandom);
    model_frame(pc_in, alu_in, ctrl_in);
    send_step(1'b0);
    capture(1'b0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dec[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL midreset_byte%0d: got %h want %h", i, dec[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    do_reset();
    for (int f = 0; f < 4; f++) begin
      pc_in = 5'($urandom_range(0, 31)); alu_in = $urandom; ctrl_in = 8'($urandom_range(0, 255));
      model_frame(pc_in, alu_in, ctrl_in);
      send_step(1'b0);
      capture(1'b0);
      for (int i = 0; i < 8; i++) begin
        total++;
        if (dec[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL random%0d_byte%0d: got %h want %h", f, i, dec[i], exp_q[i]);
        end
      end
      total++;
      if (framing_ok !== 1'b1 || busy_hi != 320) begin
        bad++;
        $display("FAIL random%0d_frame: got framing=%b busy_cycles=%0d want 1 320", f, framing_ok, busy_hi);
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
  endtask

  task automatic test_bit_timing();
    do_reset();
    pc_in = 5'h1F; alu_in = 32'h0; ctrl_in = 8'h00;
    model_frame(pc_in, alu_in, ctrl_in);
    send_step(1'b1);
    capture(1'b1);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dec[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL timing_byte%0d: got %h want %h", i, dec[i], exp_q[i]);
      end
    end
    total++;
    if (uniform_ok !== 1'b1 || framing_ok !== 1'b1) begin
      bad++;
      $display("FAIL timing_edges: got uniform=%b framing=%b want 1 1", uniform_ok, framing_ok);
    end
    total++;
    if (busy_hi != 80 * CPB_L || end_busy !== 1'b0 || end_tx !== 1'b1) begin
      bad++;
      $display("FAIL timing_busy: got busy_cycles=%0d end_busy=%b end_tx=%b want %0d 0 1", busy_hi, end_busy, end_tx, 80 * CPB_L);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_snapshot();
    test_overrun();
    test_back_to_back();
    test_step_held();
    test_reset_midframe();
    test_random_frames();
    test_bit_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
